// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush wins over push.
module fetch_buf #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills fetch_buf, hands off to decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter int unsigned          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr,
    output logic              busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]       perf_fetched,
    output logic [63:0]       perf_stall
`endif
);

    localparam int unsigned   CW   = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned   EW   = ADDR_W + 32;
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic              pop;
    logic              full;
    logic              fetch;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // halt beats start when both arrive together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !halt) state_d = RUN;
            RUN:     if (halt)           state_d = HALTED;
            HALTED:  if (start && !halt) state_d = RUN;
            default:                     state_d = IDLE;
        endcase
    end

    assign pop   = if_valid && if_ready;
    assign full  = (count == FULL);
    assign fetch = (state_q == RUN) && !redirect_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst)                 pc_q <= RESET_PC;
        else if (redirect_valid) pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
        else if (fetch)          pc_q <= pc_q + ADDR_W'(INSTR_BYTES);
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (EW)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({pc_q, imem_instr}),
        .count (count),
        .head  (head)
    );

    assign imem_addr = pc_q;
    assign if_valid  = (count != '0);
    assign if_pc     = if_valid ? head[EW-1:32] : '0;
    assign if_instr  = if_valid ? head[31:0]    : NOP_INSTR;
    assign busy      = (state_q == RUN);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (fetch && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 64'd1;
            if ((state_q == RUN) && full && !pop && (perf_stall != '1))
                perf_stall <= perf_stall + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl against a queue-based reference model.
module tb_fetch_ctrl;

    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned DEPTH     = 2;
    localparam logic [63:0] RESET_PC  = 64'h0;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        busy;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_stall;
`endif

    int vec = 0;
    int errs = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      m_q[$];
    logic [63:0] m_pc = RESET_PC;
    bit          m_run = 1'b0;
    longint unsigned m_fetched = 0;
    longint unsigned m_stall = 0;

    fetch_ctrl #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .busy           (busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h003100B3;
            64'h4:   return 32'h40628233;
            64'h8:   return 32'h009473B3;
            64'hC:   return 32'h00C5E533;
            default: return a[33:2] ^ 32'h1357_9BDF;
        endcase
    endfunction

    always_comb imem_instr = memfn(imem_addr);

    function automatic logic [161:0] dut_vec();
        return {if_valid, if_pc, if_instr, imem_addr, busy};
    endfunction

    function automatic logic [161:0] exp_vec();
        if (m_q.size() != 0)
            return {1'b1, m_q[0].pc, m_q[0].instr, m_pc, m_run};
        return {1'b0, 64'h0, NOP, m_pc, m_run};
    endfunction

    // Advance one clock: update the model from the current inputs, then sample #1 after the edge.
    task automatic step();
        bit pop, fetch;
        if (rst) begin
            m_q.delete();
            m_pc = RESET_PC;
            m_run = 1'b0;
            m_fetched = 0;
            m_stall = 0;
        end else begin
            pop   = (m_q.size() != 0) && if_ready;
            fetch = m_run && !redirect_valid && (m_q.size() < DEPTH || pop);
            if (m_run && m_q.size() == DEPTH && !pop) m_stall++;
            if (fetch) m_fetched++;
            if (redirect_valid) begin
                m_q.delete();
                m_pc = redirect_pc & ~64'h3;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (fetch) begin
                    m_q.push_back('{pc: m_pc, instr: memfn(m_pc)});
                    m_pc = m_pc + 64'd4;
                end
            end
            if (m_run && halt) m_run = 1'b0;
            else if (!m_run && start && !halt) m_run = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if (dut_vec() !== {1'b0, 64'h0, NOP, RESET_PC, 1'b0}) begin
            errs++;
            $display("FAIL reset got=%h exp=%h", dut_vec(), {1'b0, 64'h0, NOP, RESET_PC, 1'b0});
        end
        step();
        vec++;
        if (dut_vec() !== exp_vec()) begin
            errs++;
            $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_stream();
        logic [63:0] want_pc;
        do_reset();
        if_ready = 1'b1;
        pulse_start();
        want_pc = 64'h0;
        for (int i = 0; i < 8; i++) begin
            step();
            vec++;
            if (dut_vec() !== exp_vec()) begin
                errs++;
                $display("FAIL stream cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (if_valid) begin
                vec++;
                if (if_pc !== want_pc || if_instr !== memfn(want_pc)) begin
                    errs++;
                    $display("FAIL stream_seq got pc=%h instr=%h exp pc=%h instr=%h",
                             if_pc, if_instr, want_pc, memfn(want_pc));
                end
                want_pc = want_pc + 64'd4;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            step();
            vec++;
            if (dut_vec() !== exp_vec()) begin
                errs++;
                $display("FAIL bp_hold cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        vec++;
        if (imem_addr !== 64'h8 || if_pc !== 64'h0 || !if_valid) begin
            errs++;
            $display("FAIL bp_full got addr=%h pc=%h v=%b exp addr=8 pc=0 v=1", imem_addr, if_pc, if_valid);
        end
`ifdef FETCH_PERF_CNT_EN
        vec++;
        if (perf_stall !== 64'd3 || perf_fetched !== 64'd2) begin
            errs++;
            $display("FAIL perf_stall got stall=%0d fetched=%0d exp stall=3 fetched=2", perf_stall, perf_fetched);
        end
`endif
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vec++;
            if (dut_vec() !== exp_vec()) begin
                errs++;
                $display("FAIL bp_release cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        pulse_start();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h23;
        step();
        redirect_valid = 1'b0;
        vec++;
        if (if_valid !== 1'b0 || imem_addr !== 64'h20 || busy !== 1'b1) begin
            errs++;
            $display("FAIL redirect_flush got v=%b addr=%h busy=%b exp v=0 addr=20 busy=1", if_valid, imem_addr, busy);
        end
        step();
        vec++;
        if (if_valid !== 1'b1 || if_pc !== 64'h20 || if_instr !== memfn(64'h20)) begin
            errs++;
            $display("FAIL redirect_target got v=%b pc=%h instr=%h exp v=1 pc=20 instr=%h",
                     if_valid, if_pc, if_instr, memfn(64'h20));
        end
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        step();
        vec++;
        if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || imem_addr !== 64'h0) begin
            errs++;
            $display("FAIL pc_wrap got pc=%h addr=%h exp pc=fffffffffffffffc addr=0", if_pc, imem_addr);
        end
        vec++;
        if (dut_vec() !== exp_vec()) begin
            errs++;
            $display("FAIL redirect_model got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_halt();
        int n;
        do_reset();
        if_ready = 1'b1;
        pulse_start();
        n = 0;
        while (imem_addr !== 64'hC && n < 10) begin
            step();
            n++;
        end
        vec++;
        if (imem_addr !== 64'hC) begin
            errs++;
            $display("FAIL halt_reach got addr=%h exp addr=c", imem_addr);
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vec++;
            if (dut_vec() !== exp_vec()) begin
                errs++;
                $display("FAIL halt_drain cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        vec++;
        if (busy !== 1'b0 || imem_addr !== 64'h10 || if_valid !== 1'b0) begin
            errs++;
            $display("FAIL halt_hold got busy=%b addr=%h v=%b exp busy=0 addr=10 v=0", busy, imem_addr, if_valid);
        end
        pulse_start();
        n = 0;
        while (if_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        vec++;
        if (if_valid !== 1'b1 || if_pc !== 64'h10) begin
            errs++;
            $display("FAIL halt_resume got v=%b pc=%h exp v=1 pc=10", if_valid, if_pc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec++;
        if (dut_vec() !== {1'b0, 64'h0, NOP, RESET_PC, 1'b0}) begin
            errs++;
            $display("FAIL reset_mid got=%h exp=%h", dut_vec(), {1'b0, 64'h0, NOP, RESET_PC, 1'b0});
        end
        if_ready = 1'b1;
        step();
        step();
        vec++;
        if (if_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            errs++;
            $display("FAIL reset_needs_start got v=%b addr=%h exp v=0 addr=%h", if_valid, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_halt_start();
        do_reset();
        pulse_start();
        halt = 1'b1;
        start = 1'b1;
        step();
        halt = 1'b0;
        start = 1'b0;
        vec++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL halt_start got busy=%b exp busy=0", busy);
        end
        halt = 1'b1;
        start = 1'b1;
        step();
        halt = 1'b0;
        start = 1'b0;
        vec++;
        if (busy !== 1'b0 || dut_vec() !== exp_vec()) begin
            errs++;
            $display("FAIL halt_start_halted got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(63) == 0);
            start          = ($urandom_range(7) == 0);
            halt           = ($urandom_range(15) == 0);
            redirect_valid = ($urandom_range(15) == 0);
            redirect_pc    = {$urandom, $urandom};
            if_ready       = $urandom_range(1);
            step();
            vec++;
            if (dut_vec() !== exp_vec()) begin
                errs++;
                $display("FAIL random cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
`ifdef FETCH_PERF_CNT_EN
            vec++;
            if (perf_fetched !== 64'(m_fetched) || perf_stall !== 64'(m_stall)) begin
                errs++;
                $display("FAIL random_perf cyc%0d got f=%0d s=%0d exp f=%0d s=%0d",
                         i, perf_fetched, perf_stall, m_fetched, m_stall);
            end
`endif
        end
        rst = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_mid();
        test_halt_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 64-bit RISC-V core.
- Owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned 32-bit instruction together with its PC into a small buffer, and presents it to decode over a valid/ready handshake.
- Handles start/halt control and branch/jump redirects, which flush the buffer.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- BUF_DEPTH, 2, entries in the fetch buffer (power of two, ≥2).
- ADDR_W, 64, PC/address width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  pulse: leave IDLE/HALTED and begin fetching
- halt  in  1  pulse: stop issuing new fetches
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  target PC
- imem_addr  out  ADDR_W  byte address to instruction memory (= pc)
- imem_instr  in  32  instruction returned combinationally for imem_addr
- if_valid  out  1  buffer head valid
- if_ready  in  1  decode accepts head
- if_pc  out  ADDR_W  PC of head entry
- if_instr  out  32  instruction of head entry
- busy  out  1  state == RUN

Behaviour:
- Reset (rst=1 at a clk edge):
  - pc=RESET_PC, state=IDLE, buffer count=0.
  - if_valid=0, if_pc=0, if_instr=32'h00000013 (NOP), busy=0.
  - Reset mid-operation discards all buffered entries.
- State machine:
  - IDLE --start--> RUN
  - RUN --halt--> HALTED
  - HALTED --start--> RUN
  - halt and start in the same cycle: halt wins.
  - start while in RUN and halt while not in RUN are ignored.
- Fetch:
  - A fetch occurs in a RUN cycle when (count<BUF_DEPTH, or count==BUF_DEPTH and the head pops) and redirect_valid==0.
  - On a fetch, {pc, imem_instr} is pushed and pc <= pc+4 (ADDR_W wrap, no overflow flag).
- Latency: the instruction fetched in cycle N is visible on if_valid/if_pc/if_instr at cycle N+1.
- Throughput: one instruction per cycle at sustained if_ready=1.
- Handshake:
  - Head pops when if_valid && if_ready.
  - if_pc/if_instr hold stable while if_valid && !if_ready.
  - With if_valid=0, if_instr=NOP and if_pc=0.
- Full buffer with if_ready=0: no fetch, pc holds.
- Redirect (any state):
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; low bits are silently cleared.
  - Buffer flushed, if_valid=0 next cycle, no fetch that cycle, state unchanged.
  - A pop in the same cycle as a redirect is still considered accepted by decode.
- Halt: the buffer drains normally through the handshake; pc holds at the next unfetched address. Resume via start continues from that pc.
- imem_addr is combinational from the pc register only, never from inputs.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs perf_fetched (64) and perf_stall (64).
  - perf_fetched increments per fetch.
  - perf_stall increments per RUN cycle with the buffer full and no pop.
  - Both cleared by rst and saturate at all-ones.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch state enum (IDLE, RUN, HALTED)
  - NOP_INSTR = 32'h00000013
  - INSTR_BYTES = 4
- Sub-module fetch_buf: synchronous FIFO of {pc, instr}.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - flush has priority over push.

Test Plan:
- Reset, start at cycle 1, if_ready=1, mem[0..3]=003100B3,40628233,009473B3,00C5E533 -> if_valid from cycle 2; if_pc 0,4,8,C on consecutive cycles; if_instr matches.
- if_ready=0 for 5 cycles after start -> two entries buffered (pc 0,4); imem_addr stays 8; if_pc=0 held stable; release -> 0,4,8 delivered in order, no gaps.
- Redirect to 64'h23 while buffer holds pc 0,4 -> next cycle if_valid=0, imem_addr=0x20; following cycle if_pc=0x20.
- halt at pc 0x10, if_ready=1 -> remaining buffered entries drain, busy=0, imem_addr holds 0x10; start -> if_pc resumes at 0x10.
- rst asserted with a full buffer in RUN -> next cycle if_valid=0, if_instr=NOP, imem_addr=RESET_PC, busy=0; start required to refetch.
- halt and start in the same cycle in RUN -> HALTED. With FETCH_PERF_CNT_EN: 3 full-buffer stall cycles -> perf_stall=3.
